// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration chain loader.
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned BYTE_W    = 8;
    localparam bit          MSB_FIRST = 1'b1;

    // Bits of the next byte that still belong to the chain: min(BYTE_W, rem).
    function automatic logic [3:0] byte_bits(input int unsigned rem);
        return (rem >= BYTE_W) ? 4'(BYTE_W) : 4'(rem);
    endfunction

endpackage

// File: rtl/cfg_byte_serializer.sv
// Parallel-load byte shift register that emits a programmable number of bits.
module cfg_byte_serializer
    import cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [BYTE_W-1:0] data,
    input  logic [3:0]        bits,
    output logic              serial_out,
    output logic              empty
);

    logic [BYTE_W-1:0] sr;
    logic [3:0]        cnt;

    // Clearing on the last bit discards unused low bits of a partial final byte
    // and parks the serial output low between bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= data;
            cnt <= bits;
        end else if (shift && (cnt != '0)) begin
            if (cnt == 4'd1) begin
                sr <= '0;
            end else if (MSB_FIRST) begin
                sr <= sr << 1;
            end else begin
                sr <= sr >> 1;
            end
            cnt <= cnt - 4'd1;
        end
    end

    assign serial_out = MSB_FIRST ? sr[BYTE_W-1] : sr[0];
    assign empty      = (cnt == '0);

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams configuration bytes MSB-first into the fabric config chain and
// accumulates the parity of the bits that fall out of the chain tail.
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter  int unsigned CHAIN_LEN = 64,
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       ccff_head,
    output logic       ccff_shift,
    input  logic       ccff_tail,
    output logic       fabric_rst,
    output logic       busy,
    output logic       done,
    output logic       tail_parity
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [3:0]       load_bits;
    logic             load;
    logic             ser_empty;
    logic             byte_end;

    assign load_bits = byte_bits(32'(remaining));
    assign load      = (state == FETCH) && in_ready && in_valid && ser_empty;
    // Bits already shifted this pass, mod 8: a value of 7 means this edge ends a byte.
    assign byte_end  = ((3'(CHAIN_LEN) - 3'(remaining)) == 3'd7);

    cfg_byte_serializer u_ser (
        .clk        (CK),
        .rst        (RST),
        .load       (load),
        .shift      (ccff_shift),
        .data       (in_data),
        .bits       (load_bits),
        .serial_out (ccff_head),
        .empty      (ser_empty)
    );

    always_ff @(posedge CK) begin
        if (RST) begin
            state       <= IDLE;
            remaining   <= '0;
            in_ready    <= 1'b0;
            ccff_shift  <= 1'b0;
            fabric_rst  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tail_parity <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FETCH;
                        remaining   <= CNT_W'(CHAIN_LEN);
                        tail_parity <= 1'b0;
                        fabric_rst  <= 1'b1;
                        busy        <= 1'b1;
                        in_ready    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (load) begin
                        state      <= SHIFT;
                        in_ready   <= 1'b0;
                        ccff_shift <= 1'b1;
                    end
                end
                SHIFT: begin
                    tail_parity <= tail_parity ^ ccff_tail;
                    if (remaining != '0) begin
                        remaining <= remaining - 1'b1;
                    end
                    if (remaining <= CNT_W'(1)) begin
                        state      <= DONE;
                        ccff_shift <= 1'b0;
                        done       <= 1'b1;
                        fabric_rst <= 1'b0;
                        busy       <= 1'b0;
                    end else if (byte_end) begin
                        state      <= FETCH;
                        ccff_shift <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomised bench for cfg_chain_loader with 16- and 12-cell chain models.
module tb_cfg_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       sel;

    logic start16, start12;
    assign start16 = start & ~sel;
    assign start12 = start & sel;

    logic rdy16, head16, shift16, frst16, busy16, done16, par16;
    logic rdy12, head12, shift12, frst12, busy12, done12, par12;
    logic [15:0] ch16;
    logic [11:0] ch12;
    logic tail16, tail12;
    assign tail16 = ch16[15];
    assign tail12 = ch12[11];

    cfg_chain_loader #(.CHAIN_LEN(16)) dut16 (
        .CK(clk), .RST(rst), .start(start16), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy16), .ccff_head(head16), .ccff_shift(shift16), .ccff_tail(tail16),
        .fabric_rst(frst16), .busy(busy16), .done(done16), .tail_parity(par16)
    );

    cfg_chain_loader #(.CHAIN_LEN(12)) dut12 (
        .CK(clk), .RST(rst), .start(start12), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy12), .ccff_head(head12), .ccff_shift(shift12), .ccff_tail(tail12),
        .fabric_rst(frst12), .busy(busy12), .done(done12), .tail_parity(par12)
    );

    logic o_ready, o_head, o_shift, o_frst, o_busy, o_done, o_par;
    assign o_ready = sel ? rdy12   : rdy16;
    assign o_head  = sel ? head12  : head16;
    assign o_shift = sel ? shift12 : shift16;
    assign o_frst  = sel ? frst12  : frst16;
    assign o_busy  = sel ? busy12  : busy16;
    assign o_done  = sel ? done12  : done16;
    assign o_par   = sel ? par12   : par16;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nshift, ndone, nhs, done_cyc, last_shift_cyc, fr_bad, stall_bad, stall_left;
    logic [63:0] hseq;
    logic [7:0]  bytes [8];
    bit   p16 = 1'b0, p12 = 1'b0;
    logic ph16 = 1'b0, ph12 = 1'b0;

    // Advance to the next falling edge: the chain model applies the shift the DUT
    // requested in the previous cycle, then the selected loader's outputs are logged.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (p16) ch16 = {ch16[14:0], ph16};
        if (p12) ch12 = {ch12[10:0], ph12};
        p16 = shift16; ph16 = head16;
        p12 = shift12; ph12 = head12;
        if (o_shift === 1'b1) begin
            hseq = {hseq[62:0], o_head};
            nshift++;
            last_shift_cyc = cyc;
            if (o_frst !== 1'b1) fr_bad++;
        end
        if (o_done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
        end
        if (o_busy !== o_frst) fr_bad++;
        if (stall_left > 0) begin
            if (o_shift !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b1) stall_bad++;
            stall_left--;
        end
    endtask

    function automatic logic [63:0] exp_stream(input int n);
        logic [63:0] r = '0;
        logic [7:0]  b;
        for (int i = 0; i < n; i++) begin
            b = bytes[i / 8];
            r = {r[62:0], b[7 - (i % 8)]};
        end
        return r;
    endfunction

    task automatic run_pass(input bit s, input int pct, input bit keep_valid,
                            input int stall, input int restart_at, output int start_cyc);
        int  n;
        int  nb;
        int  idx;
        int  budget;
        bit  restarted;
        bit  v;
        n = s ? 12 : 16;
        nb = (n + 7) / 8;
        idx = 0;
        budget = 600;
        restarted = 1'b0;
        sel = s;
        hseq = '0; nshift = 0; ndone = 0; nhs = 0; fr_bad = 0; stall_bad = 0;
        done_cyc = -1; last_shift_cyc = -1;
        start = 1'b1;
        in_valid = 1'b0;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        stall_left = stall;
        while (ndone == 0 && budget > 0) begin
            if (stall_left > 0)      v = 1'b0;
            else if (keep_valid)     v = 1'b1;
            else if (idx >= nb)      v = 1'b0;
            else                     v = (int'($urandom_range(0, 99)) < pct);
            in_valid = v;
            in_data = (idx < nb) ? bytes[idx] : 8'($urandom);
            start = (restart_at >= 0 && !restarted && nshift == restart_at);
            if (start) restarted = 1'b1;
            if (o_ready && in_valid) begin
                nhs++;
                idx++;
            end
            tick();
            start = 1'b0;
            budget--;
        end
        in_valid = 1'b0;
        checks++;
        if (ndone == 0) begin
            errors++;
            $display("FAIL pass_timeout: done seen %0d times, required 1", ndone);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; sel = 1'b0;
        ch16 = '0; ch12 = '0;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({o_ready, o_head, o_shift, o_frst, o_busy, o_done, o_par} !== 7'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b required 0000000", s,
                         {o_ready, o_head, o_shift, o_frst, o_busy, o_done, o_par});
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic16();
        int sc;
        logic [15:0] pre;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C;
        ch16 = 16'($urandom); pre = ch16;
        run_pass(1'b0, 100, 1'b1, 0, -1, sc);
        checks++; if (hseq !== 64'hA53C) begin errors++; $display("FAIL basic_head: got %h required a53c", hseq); end
        checks++; if (nshift !== 16) begin errors++; $display("FAIL basic_shifts: got %0d required 16", nshift); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", ndone); end
        checks++; if (done_cyc !== last_shift_cyc + 1) begin errors++; $display("FAIL basic_done_timing: got %0d required %0d", done_cyc, last_shift_cyc + 1); end
        checks++; if (done_cyc - sc !== 19) begin errors++; $display("FAIL basic_latency: got %0d required 19", done_cyc - sc); end
        checks++; if (fr_bad !== 0) begin errors++; $display("FAIL basic_fabric_rst: got %0d bad cycles required 0", fr_bad); end
        checks++; if (nhs !== 2) begin errors++; $display("FAIL basic_handshakes: got %0d required 2", nhs); end
        checks++; if (o_par !== ^pre) begin errors++; $display("FAIL basic_parity: got %b required %b", o_par, ^pre); end
        checks++; if (ch16 !== 16'hA53C) begin errors++; $display("FAIL basic_chain: got %h required a53c", ch16); end
        checks++; if ({o_busy, o_frst, o_ready} !== 3'b000) begin errors++; $display("FAIL basic_idle_after: got %b required 000", {o_busy, o_frst, o_ready}); end
    endtask

    task automatic test_partial12();
        int sc;
        logic [11:0] pre;
        bytes[0] = 8'hFF; bytes[1] = 8'hF0;
        ch12 = 12'($urandom); pre = ch12;
        run_pass(1'b1, 100, 1'b1, 0, -1, sc);
        checks++; if (hseq !== 64'hFFF) begin errors++; $display("FAIL partial_head: got %h required fff", hseq); end
        checks++; if (nshift !== 12) begin errors++; $display("FAIL partial_shifts: got %0d required 12", nshift); end
        checks++; if (nhs !== 2) begin errors++; $display("FAIL partial_refetch: got %0d handshakes required 2", nhs); end
        checks++; if (done_cyc - sc !== 15) begin errors++; $display("FAIL partial_latency: got %0d required 15", done_cyc - sc); end
        checks++; if (ch12 !== 12'hFFF) begin errors++; $display("FAIL partial_chain: got %h required fff", ch12); end
        checks++; if (o_par !== ^pre) begin errors++; $display("FAIL partial_parity: got %b required %b", o_par, ^pre); end
    endtask

    task automatic test_parity();
        int sc;
        bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
        ch16 = '1;
        run_pass(1'b0, 70, 1'b0, 0, -1, sc);
        checks++; if (o_par !== 1'b0) begin errors++; $display("FAIL parity_all_ones: got %b required 0", o_par); end
        ch16 = 16'h0001 << $urandom_range(0, 15);
        run_pass(1'b0, 70, 1'b0, 0, -1, sc);
        checks++; if (o_par !== 1'b1) begin errors++; $display("FAIL parity_single_one: got %b required 1", o_par); end
    endtask

    task automatic test_stall();
        int sc;
        bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
        run_pass(1'b0, 100, 1'b0, 20, -1, sc);
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles required 0", stall_bad); end
        checks++; if (hseq !== exp_stream(16)) begin errors++; $display("FAIL stall_head: got %h required %h", hseq, exp_stream(16)); end
        checks++; if (nshift !== 16) begin errors++; $display("FAIL stall_shifts: got %0d required 16", nshift); end
    endtask

    task automatic test_restart_ignored();
        int sc;
        bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
        run_pass(1'b0, 100, 1'b0, 0, 3, sc);
        checks++; if (nshift !== 16) begin errors++; $display("FAIL restart_shifts: got %0d required 16", nshift); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL restart_done: got %0d required 1", ndone); end
        checks++; if (hseq !== exp_stream(16)) begin errors++; $display("FAIL restart_head: got %h required %h", hseq, exp_stream(16)); end
    endtask

    task automatic test_abort();
        int sc;
        int budget;
        int shifts_at_rst;
        logic [15:0] pre;
        bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
        sel = 1'b0;
        hseq = '0; nshift = 0; ndone = 0; nhs = 0;
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
        budget = 100;
        while (nshift < 5 && budget > 0) begin
            in_valid = 1'b1;
            in_data = bytes[(nhs < 2) ? nhs : 1];
            if (o_ready && in_valid) nhs++;
            tick();
            budget--;
        end
        rst = 1'b1; in_valid = 1'b0;
        tick();
        checks++;
        if ({o_ready, o_head, o_shift, o_frst, o_busy, o_done, o_par} !== 7'b0) begin
            errors++;
            $display("FAIL abort_outputs: got %b required 0000000",
                     {o_ready, o_head, o_shift, o_frst, o_busy, o_done, o_par});
        end
        rst = 1'b0;
        shifts_at_rst = nshift;
        repeat (10) tick();
        checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d required 0", ndone); end
        checks++; if (nshift !== shifts_at_rst) begin errors++; $display("FAIL abort_quiet: got %0d shifts required %0d", nshift, shifts_at_rst); end
        bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
        ch16 = 16'($urandom); pre = ch16;
        run_pass(1'b0, 80, 1'b0, 0, -1, sc);
        checks++; if (nshift !== 16) begin errors++; $display("FAIL abort_rerun_shifts: got %0d required 16", nshift); end
        checks++; if (hseq !== exp_stream(16)) begin errors++; $display("FAIL abort_rerun_head: got %h required %h", hseq, exp_stream(16)); end
        checks++; if (o_par !== ^pre) begin errors++; $display("FAIL abort_rerun_parity: got %b required %b", o_par, ^pre); end
    endtask

    task automatic test_random();
        int  sc;
        int  n;
        bit  s;
        logic pre_par;
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(0, 1) == 1;
            n = s ? 12 : 16;
            bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
            ch16 = 16'($urandom); ch12 = 12'($urandom);
            pre_par = s ? ^ch12 : ^ch16;
            run_pass(s, int'($urandom_range(30, 100)), 1'b0, 0, -1, sc);
            checks++; if (hseq !== exp_stream(n)) begin errors++; $display("FAIL rand_head[%0d]: got %h required %h", it, hseq, exp_stream(n)); end
            checks++; if (nshift !== n) begin errors++; $display("FAIL rand_shifts[%0d]: got %0d required %0d", it, nshift, n); end
            checks++; if (o_par !== pre_par) begin errors++; $display("FAIL rand_parity[%0d]: got %b required %b", it, o_par, pre_par); end
            checks++;
            if ((s ? 64'(ch12) : 64'(ch16)) !== exp_stream(n)) begin
                errors++;
                $display("FAIL rand_chain[%0d]: got %h required %h", it, s ? 64'(ch12) : 64'(ch16), exp_stream(n));
            end
            checks++; if (done_cyc !== last_shift_cyc + 1) begin errors++; $display("FAIL rand_done_timing[%0d]: got %0d required %0d", it, done_cyc, last_shift_cyc + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic16();
        test_partial12();
        test_parity();
        test_stall();
        test_restart_ignored();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
